// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Used by dmem_arbiter and its round-robin picker.
package dmem_arb_pkg;

    localparam int DEF_AW             = 32;
    localparam int DEF_DW             = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the
// port that did not win last time.
module arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner
);

    // Winner selection; the result is only meaningful when a request is up
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core port 0, loader/debug port 1) with an
// IDLE->BUSY->RESP handshake. Define DMEM_ARB_TIMEOUT_EN to add the BUSY watchdog.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          done0,
    output logic          stall0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          done1,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          err
);

    arb_state_e    state_r;
    arb_state_e    state_next_s;
    logic          last_gnt_r;
    logic          gnt_id_r;
    logic          winner_s;
    logic          any_req_s;
    logic          timeout_s;
    logic          mem_req_r;
    logic          mem_we_r;
    logic [AW-1:0] mem_adr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;
    logic          done0_r;
    logic          done1_r;

    assign any_req_s = req0 | req1;

    arb_rr2 u_rr (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_r),
        .winner   (winner_s)
    );

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_r;
    logic          err_r;

    // Watchdog: zero outside BUSY, counts BUSY cycles that see no ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= '0;
        end else if (state_r != BUSY) begin
            wd_cnt_r <= '0;
        end else if (!mem_ack) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // An ack arriving in the limit cycle takes precedence over the abort
    assign timeout_s = (state_r == BUSY) && !mem_ack &&
                       (wd_cnt_r == CW'(TIMEOUT_CYCLES - 1));

    // Abort pulse, aligned with the done pulse of the aborted access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= timeout_s;
        end
    end

    assign err = err_r;
`else
    assign timeout_s = 1'b0;

    // No watchdog state; err stays low whatever limit the parameter carries
    if (TIMEOUT_CYCLES > 0) begin : g_err_tie
        assign err = 1'b0;
    end else begin : g_err_tie_nolimit
        assign err = 1'b0;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; RESP always returns to IDLE so requests are ignored there
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Grant latch, memory-side request and per-port response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_r  <= 1'b1;
            gnt_id_r    <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_adr_r   <= '0;
            mem_wdata_r <= '0;
            rdata0_r    <= '0;
            rdata1_r    <= '0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
        end else begin
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        gnt_id_r    <= winner_s;
                        last_gnt_r  <= winner_s;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= winner_s ? we1 : we0;
                        mem_adr_r   <= winner_s ? adr1 : adr0;
                        mem_wdata_r <= winner_s ? wdata1 : wdata0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        // Read data is captured on writes as well
                        if (gnt_id_r) begin
                            rdata1_r <= mem_rdata;
                            done1_r  <= 1'b1;
                        end else begin
                            rdata0_r <= mem_rdata;
                            done0_r  <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (gnt_id_r) begin
                            done1_r <= 1'b1;
                        end else begin
                            done0_r <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    mem_req_r <= 1'b0;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_adr   = mem_adr_r;
    assign mem_wdata = mem_wdata_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign done0     = done0_r;
    assign done1     = done1_r;
    assign stall0    = req0 & ~done0_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected memory requests
// and port responses; negedge monitors pop and compare them.
module tb_dmem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } mreq_t;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wdata0, adr1, wdata1;
    logic [31:0] rdata0, rdata1;
    logic        done0, done1, stall0;
    logic        mem_req, mem_we, mem_ack, err;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic        use_fixed;
    logic [31:0] fixed_rdata;

    resp_t resp_q[$];
    mreq_t mem_q[$];
    int    checks;
    int    errors;
    int    t0, t1, te, n0, n1;

    dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .adr0      (adr0),
        .wdata0    (wdata0),
        .rdata0    (rdata0),
        .done0     (done0),
        .stall0    (stall0),
        .req1      (req1),
        .we1       (we1),
        .adr1      (adr1),
        .wdata1    (wdata1),
        .rdata1    (rdata1),
        .done1     (done1),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: address-derived read data unless a fixed word is forced
    always_comb begin
        mem_rdata = use_fixed ? fixed_rdata : (32'hC0DE_0000 ^ mem_adr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input logic port, input logic [31:0] rd, input logic e);
        resp_t r;
        r.port = port; r.rdata = rd; r.err = e;
        resp_q.push_back(r);
    endtask

    task automatic push_mem(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        mreq_t m;
        m.we = we; m.adr = adr; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    // Observe n negedges (k = 0 is the next one); record first done/err cycle
    task automatic run_cycles(input int n, input bit drop);
        t0 = -1; t1 = -1; te = -1; n0 = 0; n1 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done0) begin
                if (t0 < 0) t0 = k;
                n0++;
                if (drop) req0 = 1'b0;
            end
            if (done1) begin
                if (t1 < 0) t1 = k;
                n1++;
                if (drop) req1 = 1'b0;
            end
            if (err && te < 0) te = k;
        end
    endtask

    // Response monitor
    always @(negedge clk) begin : resp_mon
        resp_t r;
        if (!reset) begin
            if (done0 || done1) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_done", {30'd0, done1, done0}, 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    chk("done_port", {31'd0, done1}, {31'd0, r.port});
                    chk("done_rdata", r.port ? rdata1 : rdata0, r.rdata);
                    chk("done_err", {31'd0, err}, {31'd0, r.err});
                end
            end
            if (err && !(done0 || done1)) begin
                chk("err_without_done", 32'd1, 32'd0);
            end
        end
    end

    // Memory-side monitor: one expected request per acknowledged handshake
    always @(negedge clk) begin : mem_mon
        mreq_t m;
        if (!reset && mem_req && mem_ack) begin
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_ack", {31'd0, mem_req}, 32'd0);
            end else begin
                m = mem_q.pop_front();
                chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                chk("mem_adr", mem_adr, m.adr);
                chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; wdata0 = 32'd0;
        req1 = 1'b0; we1 = 1'b0; adr1 = 32'd0; wdata1 = 32'd0;
        mem_ack = 1'b0; use_fixed = 1'b0; fixed_rdata = 32'd0;
        tick(); tick();
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_adr", mem_adr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_rdata", rdata0 | rdata1, 32'd0);
        chk("rst_err_stall", {30'd0, err, stall0}, 32'd0);
        tick();
        reset = 1'b0;

        // Core store, zero-wait ack; write still captures read data
        tick();
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'd7; wdata0 = 32'h05ff_05ff;
        mem_ack = 1'b1; use_fixed = 1'b1; fixed_rdata = 32'hA5A5_0001;
        push_mem(1'b1, 32'd7, 32'h05ff_05ff);
        push_resp(1'b0, 32'hA5A5_0001, 1'b0);
        @(negedge clk);
        chk("store_stall_n", {31'd0, stall0}, 32'd1);
        chk("store_mem_req_n", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("store_mem_req_n1", {31'd0, mem_req}, 32'd1);
        chk("store_mem_we_n1", {31'd0, mem_we}, 32'd1);
        chk("store_mem_adr_n1", mem_adr, 32'd7);
        @(negedge clk);
        chk("store_done_n2", {31'd0, done0}, 32'd1);
        chk("store_stall_n2", {31'd0, stall0}, 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        // Ack held high while idle must not start or finish anything
        run_cycles(3, 1'b1);
        chk("idle_ack_ignored", {31'd0, mem_req}, 32'd0);
        chk("idle_no_done", n0 + n1, 32'd0);

        // Tie straight after reset: port 0 first, port 1 three cycles later
        tick(); reset = 1'b1;
        tick(); tick(); reset = 1'b0;
        tick();
        use_fixed = 1'b0;
        req0 = 1'b1; adr0 = 32'h10; wdata0 = 32'h11;
        req1 = 1'b1; adr1 = 32'h20; wdata1 = 32'h22;
        push_mem(1'b0, 32'h10, 32'h11);
        push_mem(1'b0, 32'h20, 32'h22);
        push_resp(1'b0, 32'hC0DE_0010, 1'b0);
        push_resp(1'b1, 32'hC0DE_0020, 1'b0);
        run_cycles(7, 1'b1);
        chk("tie_done0_cycle", t0, 32'd2);
        chk("tie_done1_cycle", t1, 32'd5);

        // Port 1 read with delayed ack; port 0 request arriving mid-access waits
        tick();
        use_fixed = 1'b1; fixed_rdata = 32'h0000_0019; mem_ack = 1'b0;
        req1 = 1'b1; adr1 = 32'd34;
        push_mem(1'b0, 32'd34, 32'h22);
        push_resp(1'b1, 32'h0000_0019, 1'b0);
        push_mem(1'b1, 32'h44, 32'h45);
        push_resp(1'b0, 32'h0000_0019, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) begin
                req0 = 1'b1; we0 = 1'b1; adr0 = 32'h44; wdata0 = 32'h45;
            end
            if (i == 4) mem_ack = 1'b1;
            @(negedge clk);
            chk("slow_mem_req", {31'd0, mem_req}, 32'd1);
            chk("slow_mem_adr", mem_adr, 32'd34);
        end
        run_cycles(6, 1'b1);
        chk("slow_done1_cycle", t1, 32'd0);
        chk("slow_done0_cycle", t0, 32'd3);
        chk("slow_rdata1_held", rdata1, 32'h0000_0019);
        we0 = 1'b0;

        // Reset mid-BUSY abandons the access; port 1 then wins on its own
        tick();
        use_fixed = 1'b0; mem_ack = 1'b0;
        req0 = 1'b1; we0 = 1'b1; adr0 = 32'h55; wdata0 = 32'h56;
        tick();
        @(negedge clk);
        chk("abort_busy_adr", mem_adr, 32'h55);
        tick();
        reset = 1'b1;
        #1;
        chk("abort_outputs", {mem_req, mem_we, done0, done1, err}, 32'd0);
        chk("abort_data", mem_adr | mem_wdata | rdata0 | rdata1, 32'd0);
        tick(); tick();
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; adr1 = 32'h66; wdata1 = 32'h67; mem_ack = 1'b1;
        push_mem(1'b0, 32'h66, 32'h67);
        push_resp(1'b1, 32'hC0DE_0066, 1'b0);
        @(negedge clk);
        chk("post_rst_idle", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("post_rst_grant", {31'd0, mem_req}, 32'd1);
        chk("post_rst_adr", mem_adr, 32'h66);
        run_cycles(3, 1'b1);
        chk("post_rst_done1", t1, 32'd0);
        chk("post_rst_no_done0", t0, 32'hFFFF_FFFF);

        // Both ports requesting continuously: grants alternate 0,1,0,1
        tick();
        req0 = 1'b1; we0 = 1'b0; adr0 = 32'h70; wdata0 = 32'h71;
        req1 = 1'b1; we1 = 1'b1; adr1 = 32'h72; wdata1 = 32'h73;
        for (int i = 0; i < 2; i++) begin
            push_mem(1'b0, 32'h70, 32'h71);
            push_resp(1'b0, 32'hC0DE_0070, 1'b0);
            push_mem(1'b1, 32'h72, 32'h73);
            push_resp(1'b1, 32'hC0DE_0072, 1'b0);
        end
        run_cycles(12, 1'b0);
        req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        chk("rr_count0", n0, 32'd2);
        chk("rr_count1", n1, 32'd2);
        chk("rr_first0", t0, 32'd2);
        chk("rr_first1", t1, 32'd5);

        // Access with no ack
        tick();
        mem_ack = 1'b0;
        req0 = 1'b1; adr0 = 32'h80; wdata0 = 32'h0;
`ifdef DMEM_ARB_TIMEOUT_EN
        push_resp(1'b0, 32'hC0DE_0070, 1'b1);
        run_cycles(20, 1'b1);
        chk("wd_done0_cycle", t0, 32'd17);
        chk("wd_err_cycle", te, 32'd17);
`else
        push_mem(1'b0, 32'h80, 32'h0);
        push_resp(1'b0, 32'hC0DE_0080, 1'b0);
        run_cycles(20, 1'b1);
        chk("wait_no_done", t0, 32'hFFFF_FFFF);
        chk("wait_no_err", te, 32'hFFFF_FFFF);
        tick();
        mem_ack = 1'b1;
        run_cycles(3, 1'b1);
        chk("wait_late_done", t0, 32'd1);
`endif

        tick(); tick();
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("mem_q_empty", mem_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
